// File: rtl/rs_pkg.sv
// Shared defaults and types for the reservation-station wakeup slice.
package rs_pkg;

  localparam int unsigned DEF_RS_ENTRIES = 8;
  localparam int unsigned DEF_PREG_W     = 6;
  localparam int unsigned DEF_PAYLOAD_W  = 32;
  localparam int unsigned DEF_CDB_WIDTH  = 2;

  typedef logic [$clog2(DEF_RS_ENTRIES)-1:0] rs_idx_t;
  typedef logic [DEF_PREG_W-1:0]             preg_tag_t;

  typedef struct packed {
    logic                     valid;
    preg_tag_t                src1_tag;
    logic                     src1_rdy;
    preg_tag_t                src2_tag;
    logic                     src2_rdy;
    preg_tag_t                dst_tag;
    logic [DEF_PAYLOAD_W-1:0] payload;
  } rs_entry_t;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: holds a micro-op and wakes its sources from
// result-tag broadcasts, including broadcasts coincident with its own write.
module rs_entry
  import rs_pkg::*;
#(
  parameter int unsigned PREG_W    = DEF_PREG_W,
  parameter int unsigned PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int unsigned CDB_WIDTH = DEF_CDB_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        wr_en,
  input  logic [PREG_W-1:0]           wr_src1_tag,
  input  logic                        wr_src1_rdy,
  input  logic [PREG_W-1:0]           wr_src2_tag,
  input  logic                        wr_src2_rdy,
  input  logic [PREG_W-1:0]           wr_dst_tag,
  input  logic [PAYLOAD_W-1:0]        wr_payload,
  input  logic                        clr,
  input  logic [CDB_WIDTH-1:0]        wb_valid,
  input  logic [CDB_WIDTH*PREG_W-1:0] wb_tag,
  output logic                        valid,
  output logic                        req,
  output logic [PREG_W-1:0]           dst_tag,
  output logic [PAYLOAD_W-1:0]        payload
);

  logic [PREG_W-1:0] src1_tag, src2_tag;
  logic              src1_rdy, src2_rdy;
  logic              hit1, hit2, wr_hit1, wr_hit2;

  always_comb begin
    hit1    = 1'b0;
    hit2    = 1'b0;
    wr_hit1 = 1'b0;
    wr_hit2 = 1'b0;
    for (int unsigned i = 0; i < CDB_WIDTH; i++) begin
      if (wb_valid[i]) begin
        if (wb_tag[i*PREG_W +: PREG_W] == src1_tag)    hit1    = 1'b1;
        if (wb_tag[i*PREG_W +: PREG_W] == src2_tag)    hit2    = 1'b1;
        if (wb_tag[i*PREG_W +: PREG_W] == wr_src1_tag) wr_hit1 = 1'b1;
        if (wb_tag[i*PREG_W +: PREG_W] == wr_src2_tag) wr_hit2 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      valid    <= 1'b1;
      src1_tag <= wr_src1_tag;
      src2_tag <= wr_src2_tag;
      src1_rdy <= wr_src1_rdy | wr_hit1;
      src2_rdy <= wr_src2_rdy | wr_hit2;
      dst_tag  <= wr_dst_tag;
      payload  <= wr_payload;
    end else begin
      if (clr)  valid    <= 1'b0;
      if (hit1) src1_rdy <= 1'b1;
      if (hit2) src2_rdy <= 1'b1;
    end
  end

  assign req = valid & src1_rdy & src2_rdy;

endmodule

// File: rtl/rs_wakeup.sv
// Reservation-station storage and tag wakeup feeding the select stage.
// Define RS_STATS_EN to add the stall_cycles / issue_count counters.
module rs_wakeup
  import rs_pkg::*;
#(
  parameter int unsigned RS_ENTRIES = DEF_RS_ENTRIES,
  parameter int unsigned PREG_W     = DEF_PREG_W,
  parameter int unsigned PAYLOAD_W  = DEF_PAYLOAD_W,
  parameter int unsigned CDB_WIDTH  = DEF_CDB_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          disp_valid,
  output logic                          disp_ready,
  input  logic [PAYLOAD_W-1:0]          disp_payload,
  input  logic [PREG_W-1:0]             disp_src1_tag,
  input  logic [PREG_W-1:0]             disp_src2_tag,
  input  logic                          disp_src1_rdy,
  input  logic                          disp_src2_rdy,
  input  logic [PREG_W-1:0]             disp_dst_tag,
  input  logic [CDB_WIDTH-1:0]          wb_valid,
  input  logic [CDB_WIDTH*PREG_W-1:0]   wb_tag,
  output logic [RS_ENTRIES-1:0]         reqs,
  input  logic [$clog2(RS_ENTRIES)-1:0] grant,
  input  logic                          grant_valid,
  output logic                          issue_valid,
  output logic [PAYLOAD_W-1:0]          issue_payload,
  output logic [PREG_W-1:0]             issue_dst_tag,
  output logic [$clog2(RS_ENTRIES):0]   occupancy
`ifdef RS_STATS_EN
  ,
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   issue_count
`endif
);

  localparam int unsigned IDX_W = $clog2(RS_ENTRIES);
  localparam int unsigned OCC_W = IDX_W + 1;

  logic [RS_ENTRIES-1:0] valid, wr_sel, clr_sel;
  logic [PREG_W-1:0]     ent_dst [RS_ENTRIES];
  logic [PAYLOAD_W-1:0]  ent_pay [RS_ENTRIES];
  logic [IDX_W-1:0]      free_idx;
  logic                  disp_fire, issue_fire;

  // Lowest-index free slot; a slot freed by this cycle's grant is not seen.
  always_comb begin
    free_idx   = '0;
    disp_ready = 1'b0;
    for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
      if (!valid[i] && !disp_ready) begin
        free_idx   = IDX_W'(i);
        disp_ready = 1'b1;
      end
    end
  end

  assign disp_fire  = disp_valid & disp_ready & ~flush;
  assign issue_fire = grant_valid & reqs[grant] & ~flush;

  always_comb begin
    wr_sel  = '0;
    clr_sel = '0;
    if (disp_fire)  wr_sel[free_idx] = 1'b1;
    if (issue_fire) clr_sel[grant]   = 1'b1;
  end

  for (genvar g = 0; g < RS_ENTRIES; g++) begin : g_entry
    rs_entry #(
      .PREG_W   (PREG_W),
      .PAYLOAD_W(PAYLOAD_W),
      .CDB_WIDTH(CDB_WIDTH)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .wr_en      (wr_sel[g]),
      .wr_src1_tag(disp_src1_tag),
      .wr_src1_rdy(disp_src1_rdy),
      .wr_src2_tag(disp_src2_tag),
      .wr_src2_rdy(disp_src2_rdy),
      .wr_dst_tag (disp_dst_tag),
      .wr_payload (disp_payload),
      .clr        (clr_sel[g]),
      .wb_valid   (wb_valid),
      .wb_tag     (wb_tag),
      .valid      (valid[g]),
      .req        (reqs[g]),
      .dst_tag    (ent_dst[g]),
      .payload    (ent_pay[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid   <= 1'b0;
      issue_payload <= '0;
      issue_dst_tag <= '0;
      occupancy     <= '0;
    end else begin
      issue_valid <= issue_fire;
      if (issue_fire) begin
        issue_payload <= ent_pay[grant];
        issue_dst_tag <= ent_dst[grant];
      end
      if (flush)
        occupancy <= '0;
      else if (disp_fire && !issue_fire)
        occupancy <= occupancy + OCC_W'(1);
      else if (!disp_fire && issue_fire)
        occupancy <= occupancy - OCC_W'(1);
    end
  end

`ifdef RS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      issue_count  <= '0;
    end else begin
      if (disp_valid && !disp_ready) stall_cycles <= stall_cycles + 32'd1;
      if (issue_fire)                issue_count  <= issue_count + 32'd1;
    end
  end
`endif

  grant_targets_ready: assert property (
    @(posedge clk) disable iff (rst) (grant_valid && !flush) |-> reqs[grant]
  ) else $warning("rs_wakeup: grant to idx %0d ignored, entry not requesting", grant);

endmodule

// File: tb/tb_rs_wakeup.sv
// Self-checking bench for rs_wakeup: directed scenarios plus randomized
// traffic against an entry-array reference model.
module tb_rs_wakeup;
  import rs_pkg::*;

  localparam int N  = 8;
  localparam int PW = 6;
  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          disp_valid = 1'b0;
  logic          disp_ready;
  logic [DW-1:0] disp_payload = '0;
  logic [PW-1:0] disp_src1_tag = '0, disp_src2_tag = '0, disp_dst_tag = '0;
  logic          disp_src1_rdy = 1'b0, disp_src2_rdy = 1'b0;
  logic [CW-1:0] wb_valid = '0;
  logic [CW*PW-1:0] wb_tag = '0;
  logic [N-1:0]  reqs;
  logic [2:0]    grant = '0;
  logic          grant_valid = 1'b0;
  logic          issue_valid;
  logic [DW-1:0] issue_payload;
  logic [PW-1:0] issue_dst_tag;
  logic [3:0]    occupancy;
`ifdef RS_STATS_EN
  logic [31:0]   stall_cycles, issue_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  rs_wakeup #(.RS_ENTRIES(N), .PREG_W(PW), .PAYLOAD_W(DW), .CDB_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_payload(disp_payload),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_dst_tag(disp_dst_tag), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .reqs(reqs), .grant(grant), .grant_valid(grant_valid),
    .issue_valid(issue_valid), .issue_payload(issue_payload),
    .issue_dst_tag(issue_dst_tag), .occupancy(occupancy)
`ifdef RS_STATS_EN
    , .stall_cycles(stall_cycles), .issue_count(issue_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the station as an array of entries.
  rs_entry_t     m_e [N];
  logic          m_iv;
  logic [DW-1:0] m_ip;
  logic [PW-1:0] m_id;
  logic [31:0]   m_stall, m_issues;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_e[i].valid) c++;
    return c;
  endfunction

  function automatic logic [N-1:0] m_reqs();
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = m_e[i].valid & m_e[i].src1_rdy & m_e[i].src2_rdy;
    return r;
  endfunction

  function automatic void model_step();
    rs_entry_t nx [N];
    bit        bc [64];
    int        cnt, ff;
    cnt = m_count();
    if (rst) begin
      for (int i = 0; i < N; i++) m_e[i] = '0;
      m_iv = 1'b0; m_ip = '0; m_id = '0; m_stall = '0; m_issues = '0;
      return;
    end
    if (disp_valid && cnt == N) m_stall++;
    if (flush) begin
      for (int i = 0; i < N; i++) m_e[i].valid = 1'b0;
      m_iv = 1'b0;
      return;
    end
    for (int t = 0; t < 64; t++) bc[t] = 1'b0;
    for (int s = 0; s < CW; s++) if (wb_valid[s]) bc[wb_tag[s*PW +: PW]] = 1'b1;
    nx = m_e;
    for (int i = 0; i < N; i++) begin
      if (bc[nx[i].src1_tag]) nx[i].src1_rdy = 1'b1;
      if (bc[nx[i].src2_tag]) nx[i].src2_rdy = 1'b1;
    end
    m_iv = grant_valid && m_e[grant].valid && m_e[grant].src1_rdy && m_e[grant].src2_rdy;
    if (m_iv) begin
      m_ip = m_e[grant].payload;
      m_id = m_e[grant].dst_tag;
      nx[grant].valid = 1'b0;
      m_issues++;
    end
    if (disp_valid && cnt < N) begin
      ff = N;
      for (int i = N - 1; i >= 0; i--) if (!m_e[i].valid) ff = i;
      nx[ff].valid    = 1'b1;
      nx[ff].src1_tag = disp_src1_tag;
      nx[ff].src2_tag = disp_src2_tag;
      nx[ff].src1_rdy = disp_src1_rdy | bc[disp_src1_tag];
      nx[ff].src2_rdy = disp_src2_rdy | bc[disp_src2_tag];
      nx[ff].dst_tag  = disp_dst_tag;
      nx[ff].payload  = disp_payload;
    end
    m_e = nx;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; disp_valid = 1'b0; wb_valid = '0; grant_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic set_disp(input logic [DW-1:0] p, input logic [PW-1:0] t1, input logic r1,
                          input logic [PW-1:0] t2, input logic r2, input logic [PW-1:0] d);
    disp_valid = 1'b1; disp_payload = p;
    disp_src1_tag = t1; disp_src1_rdy = r1;
    disp_src2_tag = t2; disp_src2_rdy = r2; disp_dst_tag = d;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (reqs !== 8'h00) begin n_bad++; $display("FAIL reset_reqs: got %b want 00000000", reqs); end
    n_cmp++; if (disp_ready !== 1'b1) begin n_bad++; $display("FAIL reset_disp_ready: got %b want 1", disp_ready); end
    n_cmp++; if (occupancy !== 4'd0) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    n_cmp++; if ({issue_valid, issue_payload, issue_dst_tag} !== '0) begin
      n_bad++; $display("FAIL reset_issue: got v=%b p=%h d=%h want all zero", issue_valid, issue_payload, issue_dst_tag);
    end
  endtask

  task automatic test_dispatch_issue();
    set_disp(32'hA5, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3); tick(); idle();
    n_cmp++; if (reqs !== 8'b0000_0001) begin n_bad++; $display("FAIL disp_reqs: got %b want 00000001", reqs); end
    n_cmp++; if (occupancy !== 4'd1) begin n_bad++; $display("FAIL disp_occ: got %0d want 1", occupancy); end
    grant = 3'd0; grant_valid = 1'b1; tick(); idle();
    n_cmp++; if (issue_valid !== 1'b1 || issue_payload !== 32'hA5 || issue_dst_tag !== 6'd3) begin
      n_bad++; $display("FAIL issue_pkt: got v=%b p=%h d=%0d want v=1 p=a5 d=3", issue_valid, issue_payload, issue_dst_tag);
    end
    n_cmp++; if (reqs !== 8'h00 || occupancy !== 4'd0) begin
      n_bad++; $display("FAIL issue_free: got reqs=%b occ=%0d want 0/0", reqs, occupancy);
    end
    tick();
    n_cmp++; if (issue_valid !== 1'b0 || issue_payload !== 32'hA5) begin
      n_bad++; $display("FAIL issue_hold: got v=%b p=%h want v=0 p=a5", issue_valid, issue_payload);
    end
  endtask

  task automatic test_wakeup();
    do_reset();
    set_disp(32'h11, 6'd5, 1'b0, 6'd0, 1'b1, 6'd7); tick(); idle();
    n_cmp++; if (reqs[0] !== 1'b0) begin n_bad++; $display("FAIL wake_wait: got %b want 0", reqs[0]); end
    wb_valid = 2'b01; wb_tag = {6'd0, 6'd5}; tick(); idle();
    n_cmp++; if (reqs[0] !== 1'b1) begin n_bad++; $display("FAIL wake_hit: got %b want 1", reqs[0]); end
    do_reset();
    set_disp(32'h22, 6'd4, 1'b1, 6'd9, 1'b0, 6'd1);
    wb_valid = 2'b10; wb_tag = {6'd9, 6'd0}; tick(); idle();
    n_cmp++; if (reqs !== 8'b0000_0001) begin n_bad++; $display("FAIL wake_same_cycle: got %b want 00000001", reqs); end
  endtask

  task automatic test_full_back_to_back();
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_disp(32'h100 + i, 6'd1, 1'b1, 6'd2, 1'b1, 6'(i)); tick();
    end
    idle();
    n_cmp++; if (disp_ready !== 1'b0 || occupancy !== 4'd8) begin
      n_bad++; $display("FAIL full: got rdy=%b occ=%0d want 0/8", disp_ready, occupancy);
    end
    set_disp(32'h77, 6'd1, 1'b1, 6'd2, 1'b1, 6'd33); grant = 3'd3; grant_valid = 1'b1; tick();
    grant_valid = 1'b0;
    n_cmp++; if (issue_valid !== 1'b1 || issue_payload !== 32'h103 || occupancy !== 4'd7 || reqs !== 8'hF7) begin
      n_bad++; $display("FAIL full_issue: got v=%b p=%h occ=%0d reqs=%b want 1/103/7/11110111",
                        issue_valid, issue_payload, occupancy, reqs);
    end
    tick(); idle();
    n_cmp++; if (occupancy !== 4'd8 || reqs !== 8'hFF || disp_ready !== 1'b0) begin
      n_bad++; $display("FAIL refill: got occ=%0d reqs=%b rdy=%b want 8/11111111/0", occupancy, reqs, disp_ready);
    end
    grant = 3'd3; grant_valid = 1'b1; tick(); idle();
    n_cmp++; if (issue_payload !== 32'h77 || issue_dst_tag !== 6'd33) begin
      n_bad++; $display("FAIL refill_slot: got p=%h d=%0d want 77/33", issue_payload, issue_dst_tag);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_disp(32'h200 + i, 6'd1, 1'b1, 6'd2, 1'b1, 6'd4); tick();
    end
    flush = 1'b1; grant = 3'd1; grant_valid = 1'b1; tick(); idle();
    n_cmp++; if (reqs !== 8'h00 || issue_valid !== 1'b0 || occupancy !== 4'd0 || disp_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush: got reqs=%b v=%b occ=%0d rdy=%b want 0/0/0/1", reqs, issue_valid, occupancy, disp_ready);
    end
  endtask

  task automatic test_bad_grant();
    do_reset();
    grant = 3'd6; grant_valid = 1'b1; tick(); idle();
    n_cmp++; if (issue_valid !== 1'b0 || occupancy !== 4'd0) begin
      n_bad++; $display("FAIL bad_grant: got v=%b occ=%0d want 0/0", issue_valid, occupancy);
    end
`ifdef RS_STATS_EN
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_disp(32'h300 + i, 6'd1, 1'b1, 6'd2, 1'b1, 6'd5); tick();
    end
    tick(); tick(); tick(); idle();
    grant = 3'd0; grant_valid = 1'b1; tick(); idle();
    flush = 1'b1; tick(); idle();
    n_cmp++; if (stall_cycles !== 32'd3 || issue_count !== 32'd1) begin
      n_bad++; $display("FAIL stats: got stall=%0d issues=%0d want 3/1", stall_cycles, issue_count);
    end
`endif
  endtask

  task automatic test_random();
    logic [2:0] g;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      flush = ($urandom_range(0, 39) == 0);
      disp_valid = ($urandom_range(0, 9) < 7);
      disp_payload = $urandom;
      disp_src1_tag = 6'($urandom_range(0, 7)); disp_src1_rdy = ($urandom_range(0, 3) == 0);
      disp_src2_tag = 6'($urandom_range(0, 7)); disp_src2_rdy = ($urandom_range(0, 3) == 0);
      disp_dst_tag = 6'($urandom_range(0, 63));
      wb_valid = 2'($urandom_range(0, 3));
      wb_tag = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      g = 3'($urandom_range(0, N - 1));
      grant = g;
      grant_valid = m_reqs()[g] && ($urandom_range(0, 2) != 0);
      tick();
      n_cmp++; if (reqs !== m_reqs()) begin n_bad++; $display("FAIL rnd_reqs c=%0d: got %b want %b", c, reqs, m_reqs()); end
      n_cmp++; if (occupancy !== 4'(m_count()) || disp_ready !== (m_count() < N)) begin
        n_bad++; $display("FAIL rnd_occ c=%0d: got occ=%0d rdy=%b want %0d/%b", c, occupancy, disp_ready, m_count(), m_count() < N);
      end
      n_cmp++; if (issue_valid !== m_iv || issue_payload !== m_ip || issue_dst_tag !== m_id) begin
        n_bad++; $display("FAIL rnd_issue c=%0d: got v=%b p=%h d=%0d want v=%b p=%h d=%0d",
                          c, issue_valid, issue_payload, issue_dst_tag, m_iv, m_ip, m_id);
      end
    end
    idle();
`ifdef RS_STATS_EN
    n_cmp++; if (stall_cycles !== m_stall || issue_count !== m_issues) begin
      n_bad++; $display("FAIL rnd_stats: got stall=%0d issues=%0d want %0d/%0d", stall_cycles, issue_count, m_stall, m_issues);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_dispatch_issue();
    test_wakeup();
    test_full_back_to_back();
    test_flush();
    test_bad_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_wakeup.md
Name: rs_wakeup

Overview:
- Reservation-station storage and tag-wakeup stage.
- Feeds the select stage: drives the per-entry ready request vector and consumes the granted index.
- Accepts one dispatched micro-op per cycle and tracks source-operand readiness from result-tag broadcasts.
- Emits the granted entry's payload as a registered issue packet and frees the entry.

Parameters:
- RS_ENTRIES, 8, number of station entries (power of two, ≥2).
- PREG_W, 6, physical register tag width.
- PAYLOAD_W, 32, opaque micro-op payload width.
- CDB_WIDTH, 2, result-tag broadcasts per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  squash all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  a free entry exists.
- disp_payload  in  PAYLOAD_W  micro-op body.
- disp_src1_tag, disp_src2_tag  in  PREG_W  each, source tags.
- disp_src1_rdy, disp_src2_rdy  in  1  each, source already available.
- disp_dst_tag  in  PREG_W  destination tag.
- wb_valid  in  CDB_WIDTH  broadcast valid bits.
- wb_tag  in  CDB_WIDTH*PREG_W  broadcast tags, slot i at [i*PREG_W +: PREG_W].
- reqs  out  RS_ENTRIES  entry valid and both sources ready.
- grant  in  $clog2(RS_ENTRIES)  index chosen by select.
- grant_valid  in  1  grant qualifier.
- issue_valid  out  1  issue packet valid.
- issue_payload  out  PAYLOAD_W  issued payload.
- issue_dst_tag  out  PREG_W  issued destination tag.
- occupancy  out  $clog2(RS_ENTRIES)+1  valid entry count.

Behaviour:
- Entry state: valid, src1 tag/ready, src2 tag/ready, dst tag, payload.
- Reset: all entries invalid, issue_valid=0, issue_payload=0, issue_dst_tag=0, occupancy=0. Consequently reqs=0 and disp_ready=1.
- Dispatch handshake:
  - Fires when disp_valid && disp_ready && !flush.
  - Writes the lowest-index invalid entry.
  - disp_ready is combinational: at least one entry invalid at start of cycle. An entry freed by a same-cycle grant is not counted.
- Wakeup:
  - Every valid entry compares both source tags against every wb_tag with wb_valid set. A match sets the ready bit at the clock edge.
  - The dispatch write also compares against the same-cycle broadcasts. A match writes rdy=1, so an entry is never left waiting on an already-broadcast tag.
  - Tag 0 is an ordinary tag with no special meaning.
- reqs[i] = valid[i] & src1_rdy[i] & src2_rdy[i], combinational from registered state. A wakeup in cycle N raises reqs in cycle N+1.
- Issue:
  - When grant_valid in cycle N and entry[grant] is valid: in cycle N+1, issue_valid=1, issue_payload and issue_dst_tag come from that entry, and the entry is invalid (reqs bit low).
  - grant_valid with an invalid or not-ready entry: the grant is ignored and issue_valid=0. A simulation assertion fires.
  - issue_valid is high for exactly one cycle per grant. Payload outputs hold their last value when issue_valid=0.
- Simultaneous events: dispatch, grant and wakeup in one cycle are all honoured. A grant frees entry k while dispatch writes a different free entry.
- Flush (dominates all other inputs):
  - All entries invalid at the edge.
  - issue_valid=0 next cycle.
  - Dispatch and grant in the flush cycle are dropped.
  - occupancy=0 next cycle.
- occupancy updates by +1 for a dispatch and −1 for an issue. Simultaneous dispatch and issue leaves it unchanged. It never exceeds RS_ENTRIES.

Optional Feature:
- RS_STATS_EN
  - Defined: adds output stall_cycles (32 bit), incremented each cycle with disp_valid && !disp_ready. Also adds output issue_count (32 bit), incremented per issue. Both counters clear on rst, are not cleared by flush, and wrap modulo 2^32.
  - Undefined: no counters and no extra ports.

Decomposition:
- Package rs_pkg holds:
  - RS_ENTRIES, PREG_W, PAYLOAD_W, CDB_WIDTH defaults.
  - typedef rs_idx_t, typedef preg_tag_t, struct rs_entry_t (valid, src tags/rdy, dst, payload).
- Sub-module rs_entry: one slot with its wakeup comparators, write, clear and flush. Instantiated RS_ENTRIES times.
- Free-slot selection stays in the top as a lowest-index priority encoder.

Test Plan:
1. Reset then dispatch src1_rdy=1, src2_rdy=1, payload=0xA5 → next cycle reqs=8'b00000001 and occupancy=1. Grant=0 → next cycle issue_valid=1, issue_payload=0xA5, reqs=0, occupancy=0.
2. Dispatch with src1_tag=5 not ready → reqs[0]=0. Broadcast wb_tag[0]=5 → reqs[0]=1 one cycle later.
3. Dispatch src2_tag=9 not ready in the same cycle as broadcast tag 9 on slot 1 → entry ready next cycle, reqs[0]=1.
4. Fill 8 entries → disp_ready=0, occupancy=8. In the same cycle issue entry 3 and hold disp_valid → dispatch accepted next cycle into entry 3.
5. Flush with grant_valid and disp_valid asserted in 4 valid entries → next cycle reqs=0, issue_valid=0, occupancy=0, disp_ready=1.
6. grant_valid=1 to invalid entry 6 → issue_valid stays 0, assertion fires. With RS_STATS_EN, 3 stalled cycles → stall_cycles=3.
